// File: rtl/pipe_stage_skid.sv
// Two-entry skid buffer pipeline register: main entry M drives the outputs, skid entry S
// absorbs the one extra beat that arrives while in_ready is still computed from registered state.
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire, out_fire;

  // in_ready depends only on registered state, so out_ready never reaches upstream combinationally
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      // data is left in place; only validity and control effects are killed
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
          state_d  = ONE;
        end
        ONE: begin
          if (in_fire && out_ready) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
            state_d  = FULL;
          end else if (out_fire) begin
            state_d  = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          state_d  = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
